// File: rtl/dar_pkg.sv
// Shared types and constants for the dar register-file arbiter.
package dar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } dar_arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-served pointer is owned by the caller.
module rr_arb2
  import dar_pkg::*;
(
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last_srv,
  output logic [1:0] gnt,
  output logic       winner
);

  // Under contention the requester that was not served last takes the slot.
  always_comb begin
    winner = REQ_A;
    if (req[0] && req[1]) begin
      winner = (last_srv == REQ_A) ? REQ_B : REQ_A;
    end else if (req[1]) begin
      winner = REQ_B;
    end
    gnt[0] = en & req[0] & (winner == REQ_A);
    gnt[1] = en & req[1] & (winner == REQ_B);
  end

endmodule

// File: rtl/dar_arb.sv
// Round-robin arbiter/sequencer serialising two requesters onto the dar register file port.
module dar_arb
  import dar_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rf_w_en,
  output logic              rf_r_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  dar_arb_state_t state;
  logic           last_srv;
  logic           cmd_id;
  logic           winner;
  logic [1:0]     gnt_vec;
  logic           sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr (
    .en       (state == IDLE),
    .req      ({b_req, a_req}),
    .last_srv (last_srv),
    .gnt      (gnt_vec),
    .winner   (winner)
  );

  assign a_gnt = gnt_vec[0];
  assign b_gnt = gnt_vec[1];

  assign sel_we    = (winner == REQ_A) ? a_we    : b_we;
  assign sel_addr  = (winner == REQ_A) ? a_addr  : b_addr;
  assign sel_wdata = (winner == REQ_A) ? a_wdata : b_wdata;

  // The registered rf_* outputs double as the latched command during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_srv   <= REQ_B;
      cmd_id     <= REQ_A;
      rf_w_en    <= 1'b0;
      rf_r_en    <= 1'b0;
      rf_addr    <= '0;
      rf_data_in <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (|gnt_vec) begin
          state      <= ACCESS;
          last_srv   <= winner;
          cmd_id     <= winner;
          rf_w_en    <= sel_we;
          rf_r_en    <= !sel_we;
          rf_addr    <= sel_addr;
          rf_data_in <= sel_wdata;
        end
      end else begin
        state      <= IDLE;
        rf_w_en    <= 1'b0;
        rf_r_en    <= 1'b0;
        rf_addr    <= '0;
        rf_data_in <= '0;
        if (rf_r_en) begin
          if (cmd_id == REQ_A) begin
            a_rdata  <= rf_data_out;
            a_rvalid <= 1'b1;
          end else begin
            b_rdata  <= rf_data_out;
            b_rvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dar_arb.sv
// Randomised scoreboard bench for dar_arb with a behavioural register file and arbitration model.
module tb_dar_arb;
  import dar_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [1:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       rf_w_en, rf_r_en;
  logic [1:0] rf_addr;
  logic [7:0] rf_data_in, rf_data_out;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  dar_arb #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_w_en(rf_w_en), .rf_r_en(rf_r_en), .rf_addr(rf_addr),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Register file attached to the arbiter's port: combinational read, clocked write.
  logic [7:0] rf_mem [4] = '{default: 8'h00};
  assign rf_data_out = rf_mem[rf_addr];
  always @(posedge clk) if (rf_w_en) rf_mem[rf_addr] <= rf_data_in;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    int         cyc;
  } rf_op_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  rf_op_t rf_q[$];
  rsp_t   a_q[$];
  rsp_t   b_q[$];

  logic [7:0] model_mem [4] = '{default: 8'h00};
  bit         busy = 0, last_b = 1, a_acc = 0, b_acc = 0;
  bit         exp_a_gnt, exp_b_gnt, exp_v;
  logic [7:0] exp_a_rdata = '0, exp_b_rdata = '0;
  int         a_wait = 0, b_wait = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cycle, actual, expected);
    end
  endtask

  // Accepted commands execute in accept order, so the model memory is updated at accept time.
  task automatic pushCmd(input logic who, input logic we, input logic [1:0] addr, input logic [7:0] data);
    rf_op_t op;
    rsp_t   rsp;
    op.we = we; op.addr = addr; op.data = data; op.cyc = cycle + 1;
    rf_q.push_back(op);
    if (we) begin
      model_mem[addr] = data;
    end else begin
      rsp.data = model_mem[addr];
      rsp.cyc  = cycle + 2;
      if (who == REQ_A) a_q.push_back(rsp);
      else b_q.push_back(rsp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; last_b = 1; a_acc = 0; b_acc = 0; a_wait = 0; b_wait = 0;
      exp_a_rdata = '0; exp_b_rdata = '0;
      rf_q.delete(); a_q.delete(); b_q.delete();
      checkOutput("reset_outputs",
                  {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, rf_w_en, rf_r_en, rf_addr, rf_data_in},
                  32'h0);
    end else begin
      exp_a_gnt = !busy && a_req && (!b_req || last_b);
      exp_b_gnt = !busy && b_req && (!a_req || !last_b);
      checkOutput("a_gnt", a_gnt, exp_a_gnt);
      checkOutput("b_gnt", b_gnt, exp_b_gnt);
      checkOutput("gnt_onehot", a_gnt & b_gnt, 0);

      if (rf_q.size() > 0 && rf_q[0].cyc == cycle) begin
        rf_op_t op;
        op = rf_q.pop_front();
        checkOutput("rf_cmd", {rf_w_en, rf_r_en, rf_addr, rf_data_in}, {op.we, !op.we, op.addr, op.data});
      end else begin
        checkOutput("rf_idle", {rf_w_en, rf_r_en, rf_addr, rf_data_in}, 0);
      end

      exp_v = a_q.size() > 0 && a_q[0].cyc == cycle;
      checkOutput("a_rvalid", a_rvalid, exp_v);
      if (exp_v) exp_a_rdata = a_q.pop_front().data;
      checkOutput("a_rdata", a_rdata, exp_a_rdata);

      exp_v = b_q.size() > 0 && b_q[0].cyc == cycle;
      checkOutput("b_rvalid", b_rvalid, exp_v);
      if (exp_v) exp_b_rdata = b_q.pop_front().data;
      checkOutput("b_rdata", b_rdata, exp_b_rdata);

      // A waiting requester must be served within one foreign command plus one access.
      a_wait = (a_req && !a_gnt) ? a_wait + 1 : 0;
      b_wait = (b_req && !b_gnt) ? b_wait + 1 : 0;
      checkOutput("a_wait_bound", a_wait > 3, 0);
      checkOutput("b_wait_bound", b_wait > 3, 0);

      busy  = 0;
      a_acc = exp_a_gnt;
      b_acc = exp_b_gnt;
      if (exp_a_gnt) begin pushCmd(REQ_A, a_we, a_addr, a_wdata); last_b = 0; busy = 1; end
      if (exp_b_gnt) begin pushCmd(REQ_B, b_we, b_addr, b_wdata); last_b = 1; busy = 1; end
    end
  end

  task automatic applyStimulus(input logic who, input logic req, input logic we,
                               input logic [1:0] addr, input logic [7:0] data);
    if (who == REQ_A) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = data;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = data;
    end
  endtask

  task automatic runCmd(input logic who, input logic we, input logic [1:0] addr, input logic [7:0] data);
    bit done = 0;
    applyStimulus(who, 1'b1, we, addr, data);
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk); #1;
      done = (who == REQ_A) ? a_acc : b_acc;
    end
    checkOutput("cmd_accept_timeout", done, 1);
    applyStimulus(who, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic newCmd(input logic who, input int pct, input bit fixed_reads);
    if (int'($urandom_range(99)) < pct) begin
      if (fixed_reads) applyStimulus(who, 1'b1, 1'b0, (who == REQ_A) ? 2'd0 : 2'd1, 8'h00);
      else applyStimulus(who, 1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)));
    end else begin
      applyStimulus(who, 1'b0, 1'b0, 2'd0, 8'h00);
    end
  endtask

  task automatic runTraffic(input int n, input int a_pct, input int b_pct, input bit fixed_reads);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (a_acc || !a_req) newCmd(REQ_A, a_pct, fixed_reads);
      if (b_acc || !b_req) newCmd(REQ_B, b_pct, fixed_reads);
    end
    for (int i = 0; i < 10 && (a_req || b_req); i++) begin
      @(posedge clk); #1;
      if (a_acc) applyStimulus(REQ_A, 1'b0, 1'b0, 2'd0, 8'h00);
      if (b_acc) applyStimulus(REQ_B, 1'b0, 1'b0, 2'd0, 8'h00);
    end
    checkOutput("traffic_drain", {a_req, b_req}, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    runCmd(REQ_A, 1'b0, 2'd3, 8'h00);
    runCmd(REQ_A, 1'b1, 2'd2, 8'h5A);
    runCmd(REQ_B, 1'b0, 2'd2, 8'h00);
    runCmd(REQ_A, 1'b1, 2'd3, 8'hFF);
    runCmd(REQ_A, 1'b0, 2'd3, 8'h00);

    applyStimulus(REQ_A, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(REQ_B, 1'b1, 1'b0, 2'd1, 8'h00);
    runTraffic(8, 100, 100, 1'b1);

    // Reset in the middle of an A read's access cycle.
    applyStimulus(REQ_A, 1'b1, 1'b0, 2'd2, 8'h00);
    for (int i = 0; i < 10 && !a_acc; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("access_rf_r_en", rf_r_en, 1);
    applyStimulus(REQ_A, 1'b0, 1'b0, 2'd0, 8'h00);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rf_r_en", rf_r_en, 0);
    checkOutput("async_reset_all",
                {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, rf_w_en, rf_r_en, rf_addr, rf_data_in},
                32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(REQ_A, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(REQ_B, 1'b1, 1'b0, 2'd1, 8'h00);
    #1;
    checkOutput("post_reset_a_first", {a_gnt, b_gnt}, 2'b10);
    runTraffic(6, 100, 100, 1'b1);

    // B raises a single read while A keeps re-requesting.
    runTraffic(0, 0, 0, 1'b0);
    applyStimulus(REQ_A, 1'b1, 1'b1, 2'd1, 8'h3C);
    @(posedge clk); #1;
    applyStimulus(REQ_B, 1'b1, 1'b0, 2'd1, 8'h00);
    runTraffic(8, 100, 0, 1'b0);

    runTraffic(300, 60, 60, 1'b0);

    checkOutput("queues_empty", rf_q.size() + a_q.size() + b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got still running, wanted finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dar_arb.md
# dar_arb

Two-port round-robin arbiter and sequencer for the 4×8 direct-addressed register file (`dar`). Two independent requesters (A, B) issue single-word read/write commands. The arbiter serialises those commands onto the register file's single `w_en`/`r_en`/`addr`/`data_in` port, captures read data into a per-requester response register, and guarantees fair access under contention.

## Interface
Parameters:
- `DATA_W`, default 8: word width; must match the register file.
- `ADDR_W`, default 2: address width; must match the register file.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset. The clock is `clk`; polarity and synchronicity are fixed.
- `a_req`, in, 1: requester A command valid. Held until granted.
- `a_we`, in, 1: A command type; 1 = write, 0 = read.
- `a_addr`, in, `ADDR_W`: A target address.
- `a_wdata`, in, `DATA_W`: A write data.
- `a_gnt`, out, 1: A command accepted this cycle.
- `a_rvalid`, out, 1: one-cycle pulse; `a_rdata` holds new read data.
- `a_rdata`, out, `DATA_W`: last read result for A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical set for requester B.
- `rf_w_en`, out, 1: register file write strobe.
- `rf_r_en`, out, 1: register file read enable.
- `rf_addr`, out, `ADDR_W`: register file address.
- `rf_data_in`, out, `DATA_W`: register file write data.
- `rf_data_out`, in, `DATA_W`: register file read data, combinational from `rf_addr`.

## Operation
- FSM has two states.
  - `IDLE`: arbitrate and accept.
  - `ACCESS`: drive the register file for exactly one cycle.
- In `IDLE`, the winner is chosen as follows:
  - Only one `req` high: that requester wins.
  - Both high: the requester not served last wins.
  - `last_srv` resets to B, so A wins the first contention.
- `x_gnt = (state==IDLE) & x_req & (winner==x)`, combinational. A command is accepted at a rising edge with `req & gnt` high.
- On accept:
  - latch `we`, `addr`, `wdata` and the requester id;
  - update `last_srv`;
  - go to `ACCESS`.
- The requester may change or drop its inputs after acceptance.
- In `ACCESS`:
  - `rf_addr` and `rf_data_in` come from the latched command;
  - `rf_w_en = we`, `rf_r_en = !we`;
  - on the next edge, return to `IDLE`.
  - For a read, capture `rf_data_out` into the owner's `rdata` and set that owner's `rvalid` for one cycle.
- Outside `ACCESS`, all `rf_*` outputs are 0.
- `x_rdata` holds its value until that requester's next read completes. Writes produce no `rvalid`.
- A requester with `req` high and not granted keeps its command pending. No command is dropped and none is duplicated.
- `gnt` is never asserted in `ACCESS`, even if `req` is high.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - state = `IDLE`, `last_srv` = B;
  - all `gnt` = 0, `rvalid` = 0, `rdata` = 0;
  - all `rf_*` = 0.
- Accept at cycle 0 (`gnt` high):
  - cycle 1 is `ACCESS` with the `rf` strobe high;
  - the write is committed at the end of cycle 1;
  - the read result has `rvalid` = 1 in cycle 2.
- Read latency: 2 cycles from the `gnt` cycle.
- Throughput: one command per 2 cycles. The next `gnt` is possible in cycle 2, the same cycle as the preceding `rvalid`.
- Continuous contention alternates A, B, A, B… with one grant every 2 cycles per pair slot.
- Reset asserted during `ACCESS`:
  - all `rf_*` drop immediately;
  - the in-flight command is abandoned;
  - no `rvalid` is produced;
  - the arbiter returns to `IDLE` with `last_srv` = B.
- Simultaneous `req` rise with the arbiter in `ACCESS`: no grant until `IDLE`, then round-robin applies.

## Structure
- Package `dar_pkg` holds:
  - the state typedef `dar_arb_state_t` {`IDLE`, `ACCESS`};
  - the requester id constants `REQ_A` = 0, `REQ_B` = 1;
  - the default `DATA_W` / `ADDR_W` localparams.
- Sub-module `rr_arb2`: a 2-way round-robin picker.
  - Inputs: two request bits, `last_srv`, and an enable.
  - Outputs: one-hot grant and the winner id.
  - The pointer lives in `dar_arb` so that reset and update stay with the FSM.
- Everything else is inline: the FSM, the command latch, and the response registers.

## Test plan
- Reset, then A writes addr 2 with 0x5A: `a_gnt` in cycle 0; `rf_w_en` = 1, `rf_addr` = 2, `rf_data_in` = 0x5A in cycle 1; no `a_rvalid`.
- Then B reads addr 2: `b_gnt` in cycle 0; `rf_r_en` = 1 in cycle 1; `b_rvalid` = 1 and `b_rdata` = 0x5A in cycle 2; `a_rdata` stays unchanged.
- `a_req` and `b_req` both held high from reset, reading addr 0 and addr 1: grant order A, B, A, B at cycles 0, 2, 4, 6; never two `gnt` signals in the same cycle.
- Read of an unwritten addr 3 after reset returns 0x00 with `rvalid` in cycle 2. Write addr 3 with 0xFF, read it back, and expect 0xFF.
- Assert `rst_n` = 0 during `ACCESS` of an A read: `rf_r_en` drops immediately, `a_rvalid` never pulses, and all outputs are 0. After release, the first contention grants A.
- B holds `req` for 5 cycles while A repeatedly wins single requests: B must be granted no later than the second `IDLE` after its request, and its command must be executed exactly once.
